input_conditioner: RTL and testbench

Front-end conditioning stage that sits directly upstream of the CPU's `Enter` and `sw` inputs. It synchronises the raw push-button and slide-switch pins to `CLK` and debounces them. It emits a single-cycle `Enter` strobe per physical press, together with a clean switch word. It also latches a snapshot of the switches at each press, so the IO input instruction reads a value that cannot change mid-transfer.

---
 rtl/input_conditioner.sv | 155 +++++++++++++++
 tb/tb_input_conditioner.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner
// Front-end conditioning for the CPU's Enter key and slide switches.
// Raw pins are brought into the CLK domain through two-flop synchronisers
// and then debounced. Each accepted key press produces one registered
// enter_pulse and takes a snapshot of the debounced switch word. The CPU
// reads that snapshot, so its value cannot change in the middle of a transfer.
//
// Ports
//   CLK          system clock (the only clock in this block)
//   reset        asynchronous reset, active low
//   key_n        raw Enter push button, active low, asynchronous to CLK
//   sw_raw       raw slide switches, asynchronous to CLK
//   enter_pulse  one-cycle strobe per accepted press
//   enter_level  debounced "key held" level
//   sw_stable    debounced switch word
//   sw_captured  sw_stable snapshot taken at each accepted press
//   press_count  accepted presses, modulo 256
//
// Key FSM
//   state      | meaning
//   -----------+--------------------------------------------------
//   IDLE       | key released and debounced
//   DB_PRESS   | key seen pressed, counting stable cycles
//   HELD       | press accepted (pulse issued on entry)
//   DB_RELEASE | key seen released, counting stable cycles
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20,
    parameter int SW_WIDTH        = 10
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                key_n,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic                enter_pulse,
    output logic                enter_level,
    output logic [SW_WIDTH-1:0] sw_stable,
    output logic [SW_WIDTH-1:0] sw_captured,
    output logic [7:0]          press_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_TC  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } key_state_t;

    logic                key_s1;
    logic                key_s2;
    logic [SW_WIDTH-1:0] sw_s1;
    logic [SW_WIDTH-1:0] sw_sync;
    logic                key_s;

    key_state_t          key_state;
    logic [CNT_WIDTH-1:0] kcnt;

    logic [SW_WIDTH-1:0] cand;
    logic [CNT_WIDTH-1:0] scnt;

    // Key stages reset to "released" so a button held through reset is
    // seen as a fresh press once reset is removed.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            key_s1  <= 1'b1;
            key_s2  <= 1'b1;
            sw_s1   <= '0;
            sw_sync <= '0;
        end else begin
            key_s1  <= key_n;
            key_s2  <= key_s1;
            sw_s1   <= sw_raw;
            sw_sync <= sw_s1;
        end
    end

    assign key_s = ~key_s2;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            key_state   <= IDLE;
            kcnt        <= '0;
            enter_pulse <= 1'b0;
            enter_level <= 1'b0;
            press_count <= 8'd0;
            sw_captured <= '0;
        end else begin
            enter_pulse <= 1'b0;
            case (key_state)
                IDLE: begin
                    if (key_s) begin
                        key_state <= DB_PRESS;
                        kcnt      <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!key_s) begin
                        key_state <= IDLE;
                    end else if (kcnt == CNT_TC) begin
                        key_state   <= HELD;
                        enter_pulse <= 1'b1;
                        enter_level <= 1'b1;
                        press_count <= press_count + 8'd1;
                        // Non-blocking read gives the pre-edge word, so a
                        // switch update landing on this same edge is excluded.
                        sw_captured <= sw_stable;
                    end else begin
                        kcnt <= kcnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!key_s) begin
                        key_state <= DB_RELEASE;
                        kcnt      <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (key_s) begin
                        key_state <= HELD;
                    end else if (kcnt == CNT_TC) begin
                        key_state   <= IDLE;
                        enter_level <= 1'b0;
                    end else begin
                        kcnt <= kcnt + CNT_ONE;
                    end
                end
                default: begin
                    key_state <= IDLE;
                end
            endcase
        end
    end

    // One window for the whole switch word: any bit moving restarts it.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cand      <= '0;
            scnt      <= '0;
            sw_stable <= '0;
        end else if (sw_sync != cand) begin
            cand <= sw_sync;
            scnt <= '0;
        end else if (cand != sw_stable) begin
            if (scnt == CNT_TC) begin
                sw_stable <= cand;
            end else begin
                scnt <= scnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

    localparam int D  = 4;
    localparam int SW = 10;

    logic          CLK;
    logic          reset;
    logic          key_n;
    logic [SW-1:0] sw_raw;
    logic          enter_pulse;
    logic          enter_level;
    logic [SW-1:0] sw_stable;
    logic [SW-1:0] sw_captured;
    logic [7:0]    press_count;

    int vectors    = 0;
    int miscompares = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH(20),
        .SW_WIDTH(SW)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .key_n(key_n),
        .sw_raw(sw_raw),
        .enter_pulse(enter_pulse),
        .enter_level(enter_level),
        .sw_stable(sw_stable),
        .sw_captured(sw_captured),
        .press_count(press_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: a press/release is accepted once the synchronised key
    // has disagreed with the debounced level for D+1 consecutive samples; the
    // switch word is accepted once it has read the same new value for D+1
    // consecutive samples. Raw inputs reach the logic two edges late.
    bit            m_kq[$];
    logic [SW-1:0] m_sq[$];
    bit            m_kh[$];
    logic [SW-1:0] m_sh[$];
    bit            m_level;
    bit            m_pulse;
    logic [7:0]    m_count;
    logic [SW-1:0] m_stable;
    logic [SW-1:0] m_cap;

    function automatic void model_reset();
        m_kq.delete();
        m_kq.push_back(1'b1);
        m_kq.push_back(1'b1);
        m_sq.delete();
        m_sq.push_back('0);
        m_sq.push_back('0);
        m_kh.delete();
        m_sh.delete();
        m_level  = 1'b0;
        m_pulse  = 1'b0;
        m_count  = 8'd0;
        m_stable = '0;
        m_cap    = '0;
    endfunction

    function automatic void model_step();
        bit            ks;
        bit            flip;
        bit            same;
        logic [SW-1:0] ss;
        logic [SW-1:0] old_stable;
        if (!reset) begin
            model_reset();
            return;
        end
        old_stable = m_stable;
        m_kq.push_back(key_n);
        ks = !m_kq.pop_front();
        m_sq.push_back(sw_raw);
        ss = m_sq.pop_front();
        m_kh.push_back(ks);
        if (m_kh.size() > D + 1) void'(m_kh.pop_front());
        m_sh.push_back(ss);
        if (m_sh.size() > D + 1) void'(m_sh.pop_front());
        m_pulse = 1'b0;
        if (m_kh.size() == D + 1) begin
            flip = 1'b1;
            foreach (m_kh[i]) if (m_kh[i] == m_level) flip = 1'b0;
            if (flip) begin
                m_level = !m_level;
                if (m_level) begin
                    m_pulse = 1'b1;
                    m_count = m_count + 8'd1;
                    m_cap   = old_stable;
                end
            end
        end
        if (m_sh.size() == D + 1 && ss != m_stable) begin
            same = 1'b1;
            foreach (m_sh[i]) if (m_sh[i] != ss) same = 1'b0;
            if (same) m_stable = ss;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge: update the model with the inputs the edge sampled, then
    // compare every output against it just after the edge.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        check("model_pulse",   {31'd0, enter_pulse}, {31'd0, m_pulse});
        check("model_level",   {31'd0, enter_level}, {31'd0, m_level});
        check("model_count",   {24'd0, press_count}, {24'd0, m_count});
        check("model_stable",  {22'd0, sw_stable},   {22'd0, m_stable});
        check("model_capture", {22'd0, sw_captured}, {22'd0, m_cap});
    endtask

    typedef struct {
        logic          key_n;
        logic [SW-1:0] sw;
        logic          exp_pulse;
        logic          exp_level;
        logic [7:0]    exp_count;
        logic [SW-1:0] exp_stable;
        logic [SW-1:0] exp_cap;
    } vec_t;

    localparam int NV = 28;
    vec_t vt[NV];

    int pulses;
    int start_count;
    bit prev_pulse;
    int krun;
    int srun;

    initial begin
        // Clean press: switches settle first, key pressed at row 9, released
        // at row 20. Rows are 1-based edge numbers after reset release.
        for (int r = 1; r <= NV; r++) begin
            vt[r-1].key_n      = (r >= 9 && r < 20) ? 1'b0 : 1'b1;
            vt[r-1].sw         = 10'h2A5;
            vt[r-1].exp_stable = (r >= 7) ? 10'h2A5 : 10'h000;
            vt[r-1].exp_pulse  = (r == 15);
            vt[r-1].exp_level  = (r >= 15 && r < 26);
            vt[r-1].exp_count  = (r >= 15) ? 8'd1 : 8'd0;
            vt[r-1].exp_cap    = (r >= 15) ? 10'h2A5 : 10'h000;
        end

        // Reset held with random inputs.
        reset  = 1'b0;
        key_n  = 1'b0;
        sw_raw = '0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            key_n  = 1'($urandom);
            sw_raw = SW'($urandom);
            tick();
            check("rst_outputs", {enter_pulse, enter_level, sw_stable, sw_captured, press_count}, 32'd0);
        end
        #1;
        reset  = 1'b1;
        key_n  = 1'b1;
        sw_raw = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_outputs", {enter_pulse, enter_level, sw_stable, sw_captured, press_count}, 32'd0);
        end

        // Reset once more so the table rows line up with edge numbers.
        reset = 1'b0;
        model_reset();
        tick();
        #1;
        reset = 1'b1;
        for (int r = 0; r < NV; r++) begin
            key_n  = vt[r].key_n;
            sw_raw = vt[r].sw;
            tick();
            check("tbl_pulse",  {31'd0, enter_pulse}, {31'd0, vt[r].exp_pulse});
            check("tbl_level",  {31'd0, enter_level}, {31'd0, vt[r].exp_level});
            check("tbl_count",  {24'd0, press_count}, {24'd0, vt[r].exp_count});
            check("tbl_stable", {22'd0, sw_stable},   {22'd0, vt[r].exp_stable});
            check("tbl_cap",    {22'd0, sw_captured}, {22'd0, vt[r].exp_cap});
        end

        // Bounce: toggle every cycle, then released, then a real hold.
        start_count = int'(press_count);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            if (enter_pulse) pulses++;
        end
        key_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (enter_pulse) pulses++;
        end
        check("bounce_no_pulse", pulses, 0);
        check("bounce_count", {24'd0, press_count}, start_count);
        key_n = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (enter_pulse) pulses++;
        end
        check("hold_one_pulse", pulses, 1);
        check("hold_count", {24'd0, press_count}, (start_count + 1) % 256);
        key_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Switch debounce with bit 0 bouncing; final value first sampled at edge 4.
        sw_raw = '0;
        for (int i = 0; i < 10; i++) tick();
        check("sw_zero", {22'd0, sw_stable}, 32'd0);
        for (int i = 1; i <= 14; i++) begin
            sw_raw = (i == 1 || i == 3) ? 10'h3FE : 10'h3FF;
            tick();
            check("sw_bounce", {22'd0, sw_stable}, (i >= 10) ? 32'h3FF : 32'h0);
        end

        // 256 clean presses wrap the counter.
        start_count = int'(press_count);
        pulses = 0;
        prev_pulse = 1'b0;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 24; i++) begin
                key_n = (i < 12) ? 1'b0 : 1'b1;
                tick();
                if (enter_pulse) pulses++;
                if (prev_pulse && enter_pulse) check("wrap_double_pulse", 1, 0);
                prev_pulse = enter_pulse;
            end
        end
        check("wrap_pulses", pulses, 256);
        check("wrap_count", {24'd0, press_count}, start_count);

        // Reset during DB_PRESS with kcnt at 2, key held through release.
        key_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_pre_pulse", {31'd0, enter_pulse}, 32'd0);
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_held", {enter_pulse, enter_level, press_count}, 32'd0);
        end
        #1;
        reset = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check("midrst_pulse", {31'd0, enter_pulse}, (e == 7) ? 32'd1 : 32'd0);
        end
        check("midrst_count", {24'd0, press_count}, 32'd1);
        key_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Random runs on key and switches, occasional reset.
        krun = 1;
        srun = 1;
        prev_pulse = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            krun--;
            if (krun == 0) begin
                key_n = ~key_n;
                krun = int'($urandom_range(1, 10));
            end
            srun--;
            if (srun == 0) begin
                sw_raw = SW'($urandom);
                srun = int'($urandom_range(1, 9));
            end
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            tick();
            if (prev_pulse && enter_pulse) check("rand_double_pulse", 1, 0);
            prev_pulse = enter_pulse;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
